dsp_out_norm: RTL and testbench

//   Output stage after the last dsp16x8 in the filter cascade. Takes the signed
//   48-bit accumulated sum (p_o of the final tap) and divides it by 2^SHIFT with

---
 rtl/dsp_pkg.sv | 28 ++
 rtl/norm_fifo.sv | 65 ++++++
 rtl/dsp_out_norm.sv | 105 ++++++++++
 tb/tb_dsp_out_norm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared widths and pixel clamp for the dsp16x8 cascade and its
//               output normaliser.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    localparam int DSP_P_W = 48;
    localparam int PIX_W   = 8;
    localparam int PIX_MAX = 255;

    // Returns {sat, pixel}; the input is the already shifted, sign-extended sum.
    function automatic logic [PIX_W:0] clamp_pix(input logic signed [DSP_P_W:0] s);
        logic [PIX_W:0] res;
        if (s < 0) begin
            res = {1'b1, {PIX_W{1'b0}}};
        end else if (s > PIX_MAX) begin
            res = {1'b1, {PIX_W{1'b1}}};
        end else begin
            res = {1'b0, s[PIX_W-1:0]};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/norm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : norm_fifo
// Description : Synchronous FIFO with extra pointer bit for full/empty, no
//               bypass path. Overflow policy belongs to the instantiating block.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_fifo
    import dsp_pkg::*;
#(
    parameter int WIDTH = PIX_W + 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd;
    logic             w_wr;

    assign level   = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (level == C_DEPTH);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // A write into a full FIFO is legal only when the head leaves on the same
    // edge; it then lands in the slot being vacated.
    assign w_rd = rd_en && !empty;
    assign w_wr = wr_en && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_out_norm.sv
`default_nettype none
// ============================================================================
// Module      : dsp_out_norm
// Description : Rounds/shifts the cascade sum, clamps to an 8-bit pixel and
//               buffers it toward the sink. Define NORM_ROUND_EN for round
//               half up; otherwise the shift floors.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_out_norm
    import dsp_pkg::*;
#(
    parameter int SHIFT = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DSP_P_W-1:0]       p_i,
    input  logic                     p_valid_i,
    output logic [PIX_W-1:0]         px_o,
    output logic                     px_sat_o,
    output logic                     px_valid_o,
    input  logic                     px_ready_i,
    output logic                     ovf_o,
    output logic [$clog2(DEPTH):0]   level_o
);

`ifdef NORM_ROUND_EN
    localparam logic signed [DSP_P_W:0] C_RND =
        (SHIFT > 0) ? ((DSP_P_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic signed [DSP_P_W:0] C_RND = '0;
`endif

    logic signed [DSP_P_W:0] r_s1;
    logic                    r_v1;
    logic [PIX_W:0]          r_px2;
    logic                    r_v2;
    logic                    r_ovf;

    logic signed [DSP_P_W:0] w_sum;
    logic signed [DSP_P_W:0] w_shift;
    logic [PIX_W:0]          w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_wr;

    // One extra bit keeps the rounding add from wrapping at the 48-bit limits.
    assign w_sum   = $signed({p_i[DSP_P_W-1], p_i}) + C_RND;
    assign w_shift = r_s1 >>> SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= p_valid_i;
            r_v2 <= r_v1;
        end
    end

    // Data registers only move with a valid sample and need no reset.
    always_ff @(posedge clk) begin
        if (p_valid_i) begin
            r_s1 <= w_sum;
        end
        if (r_v1) begin
            r_px2 <= clamp_pix(w_shift);
        end
    end

    assign w_pop = !w_empty && px_ready_i;
    assign w_wr  = r_v2 && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_v2 && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    norm_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data (r_px2),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level_o)
    );

    // The memory is not reset, so the head is masked while nothing is stored.
    assign px_valid_o = !w_empty;
    assign px_o       = w_empty ? '0   : w_head[PIX_W-1:0];
    assign px_sat_o   = w_empty ? 1'b0 : w_head[PIX_W];
    assign ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_out_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_out_norm
// Description : Scoreboard bench for dsp_out_norm (SHIFT=7, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_out_norm;

    localparam int SHIFT = 7;
    localparam int DEPTH = 4;
`ifdef NORM_ROUND_EN
    localparam longint RND = 64;
`else
    localparam longint RND = 0;
`endif

    typedef struct packed {
        bit       v;
        bit [7:0] px;
        bit       sat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] p_i = '0;
    logic        p_valid_i = 1'b0;
    logic [7:0]  px_o;
    logic        px_sat_o;
    logic        px_valid_o;
    logic        px_ready_i = 1'b0;
    logic        ovf_o;
    logic [2:0]  level_o;

    longint p_cur = 0;
    int     errors = 0;
    int     checks = 0;
    bit     started = 0;

    ent_t   pipe[$];
    ent_t   exp_q[$];
    int     mocc = 0;
    bit     movf = 0;

    dsp_out_norm #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_i        (p_i),
        .p_valid_i  (p_valid_i),
        .px_o       (px_o),
        .px_sat_o   (px_sat_o),
        .px_valid_o (px_valid_o),
        .px_ready_i (px_ready_i),
        .ovf_o      (ovf_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pixel = clamp(floor((p + RND) / 2^SHIFT)).
    function automatic ent_t ref_pix(input longint p, input bit v);
        ent_t   e;
        longint x, d, q;
        x = p + RND;
        d = longint'(1) << SHIFT;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        e.v = v;
        if (q < 0) begin
            e.px = 8'd0;   e.sat = 1'b1;
        end else if (q > 255) begin
            e.px = 8'd255; e.sat = 1'b1;
        end else begin
            e.px = 8'(q);  e.sat = 1'b0;
        end
        return e;
    endfunction

    // Model: two-edge delay line feeding a bounded queue that drops when full.
    always @(posedge clk) begin
        ent_t w;
        bit   pop;
        bit   was_full;
        started = 1;
        if (rst) begin
            pipe.delete();
            pipe.push_back('0);
            pipe.push_back('0);
            exp_q.delete();
            mocc = 0;
            movf = 0;
        end else begin
            w = pipe.pop_front();
            pipe.push_back(ref_pix(p_cur, p_valid_i));
            was_full = (mocc == DEPTH);
            pop = (mocc > 0) && px_ready_i;
            if (pop) mocc--;
            if (w.v) begin
                if (was_full && !pop) begin
                    movf = 1;
                end else begin
                    exp_q.push_back(w);
                    mocc++;
                end
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        ent_t e;
        if (started) begin
            chk("valid", px_valid_o, mocc > 0);
            chk("level", level_o, mocc);
            chk("ovf", ovf_o, movf);
            if (px_valid_o && px_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("px", px_o, e.px);
                    chk("sat", px_sat_o, e.sat);
                end
            end
        end
    end

    task automatic step(input longint p, input bit v, input bit rdy, input bit r = 1'b0);
        p_cur      = p;
        p_i        = p[47:0];
        p_valid_i  = v;
        px_ready_i = rdy;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, rdy);
    endtask

    function automatic longint rand_p();
        logic [63:0] x;
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 45000)) - 5000;
            1: begin
                x = {$urandom, $urandom};
                return longint'($signed(x[47:0]));
            end
            2: return 32640 + longint'($urandom_range(0, 400)) - 200;
            default: return longint'($urandom_range(0, 256)) - 128;
        endcase
    endfunction

    initial begin
        longint seq [9];
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        @(negedge clk);
        chk("rst_px", px_o, 0);
        chk("rst_sat", px_sat_o, 0);
        chk("rst_valid", px_valid_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_level", level_o, 0);
        #1;

        // Directed values: rounding, negative, and both clamp limits.
        seq = '{6400, 6463, 6464, -64, -8355840, 40000, 32640, 32704, 127};
        for (int i = 0; i < 9; i++) begin
            step(seq[i], 1, 1);
            idle(4, 1);
        end

        // Overflow with sink stalled, then drain.
        for (int k = 1; k <= 6; k++) step(k * 128, 1, 0);
        idle(3, 0);
        idle(8, 1);

        // Full FIFO: pop and write on the same edge.
        step(0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) step(k * 128, 1, 0);
        step(5 * 128, 1, 0);
        idle(1, 0);
        idle(1, 1);
        idle(2, 0);
        idle(6, 1);

        // Reset with samples in pipeline and FIFO, then latency after reset.
        for (int k = 1; k <= 5; k++) step(k * 128, 1, 0);
        step(0, 0, 0, 1);
        step(9 * 128, 1, 1);
        idle(5, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(rand_p(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 150) == 0);
        end

        idle(12, 1);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
